// File: rtl/sdp_rd_arbiter.sv
// Round-robin arbiter sharing one single-port read memory among N requesters.
// Issues at most one read per cycle and routes each 1-cycle-latency response back to its issuer.
module sdp_rd_arbiter #(
  parameter int W_DATA = 16,
  parameter int W_ADDR = 16,
  parameter int N      = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        addr_valid_i,
  input  logic [N*W_ADDR-1:0] addr_data_i,
  output logic [N-1:0]        addr_ready_o,
  output logic [N-1:0]        data_valid_o,
  output logic [N*W_DATA-1:0] data_data_o,
  output logic [N-1:0]        data_eot_o,
  input  logic [N-1:0]        data_ready_i,
  output logic                en_o,
  output logic [W_ADDR-1:0]   addr_o,
  input  logic [W_DATA-1:0]   data_i
);

  localparam int W_ID = $clog2(N);

  logic            out_valid_q, out_valid_d;
  logic [W_ID-1:0] out_id_q, out_id_d;
  logic [W_ID-1:0] rr_ptr_q, rr_ptr_d;
  logic [W_ID-1:0] grant_s;
  logic [W_ID-1:0] scan_idx_s;
  logic            any_valid_s;
  logic            stall_s;

  function automatic logic [W_ID-1:0] wrap_add(input logic [W_ID-1:0] base, input int k);
    return W_ID'((int'(base) + k) % N);
  endfunction

  assign stall_s = out_valid_q & ~data_ready_i[out_id_q];

  // Round-robin scan; iterating downward lets the first hit from rr_ptr win last.
  always_comb begin
    grant_s     = '0;
    any_valid_s = 1'b0;
    scan_idx_s  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      scan_idx_s  = wrap_add(rr_ptr_q, k);
      grant_s     = addr_valid_i[scan_idx_s] ? scan_idx_s : grant_s;
      any_valid_s = any_valid_s | addr_valid_i[scan_idx_s];
    end
  end

  // Issue is gated by rst so nothing is accepted while reset is held.
  always_comb begin
    en_o         = rst & ~stall_s & any_valid_s;
    addr_o       = addr_data_i[grant_s*W_ADDR +: W_ADDR];
    addr_ready_o = '0;
    addr_ready_o[grant_s] = en_o;
  end

  // Next-state: hold everything on stall, otherwise track the newest issue.
  always_comb begin
    out_valid_d = out_valid_q;
    out_id_d    = out_id_q;
    rr_ptr_d    = rr_ptr_q;
    if (!stall_s) begin
      out_valid_d = en_o;
      out_id_d    = en_o ? grant_s : out_id_q;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (en_o) begin
      rr_ptr_d = wrap_add(grant_s, 1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_resp
    assign data_valid_o[i] = out_valid_q & (out_id_q == W_ID'(i));
  end

  assign data_data_o = {N{data_i}};
  assign data_eot_o  = '0;

endmodule
